// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter with hold cap driving the 4:1 mux selects
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       select1,
  output logic       select2,
  output logic [1:0] owner,
  output logic       busy
);
  typedef enum logic {IDLE, GRANTED} state_t;
  state_t state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [3:0] nxt_grant;
  logic [1:0] nxt_owner, win;
  logic hold;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      owner <= 2'd3;
      cnt <= '0;
    end else begin
      state <= nxt_state;
      grant <= nxt_grant;
      owner <= nxt_owner;
      cnt <= nxt_cnt;
    end
  end
  // scanning downward lets the channel nearest owner+1 overwrite the rest
  always_comb begin
    win = owner;
    for (int k = 4; k >= 1; k--)
      if (req[owner + 2'(k)]) win = owner + 2'(k);
  end
  assign hold = state == GRANTED && req[owner] && cnt < CNT_W'(MAX_HOLD);
  always_comb begin
    nxt_state = |req ? GRANTED : IDLE;
    nxt_owner = |req ? win : owner;
    nxt_grant = |req ? 4'b0001 << win : 4'b0000;
    nxt_cnt = |req ? CNT_W'(1) : '0;
    if (hold) begin
      nxt_state = GRANTED;
      nxt_owner = owner;
      nxt_grant = grant;
      nxt_cnt = cnt + CNT_W'(1);
    end
  end
  assign select1 = owner[0];
  assign select2 = owner[1];
  assign busy = state == GRANTED;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: table-driven check of MAX_HOLD=4 and a MAX_HOLD=1 rotation sequence
module tb_mux_rr_arbiter;
  logic clk = 0;
  logic reset, reset1;
  logic [3:0] req, req1, grant, grant1;
  logic select1, select2, busy, select1_1, select2_1, busy1;
  logic [1:0] owner, owner1;
  int passed = 0, total = 0;
  typedef struct {
    logic rst;
    logic [3:0] req;
    logic [3:0] g;
    logic [1:0] o;
    logic b;
  } vec_t;
  vec_t v[$];
  always #5 clk = ~clk;
  mux_rr_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant),
    .select1(select1), .select2(select2), .owner(owner), .busy(busy)
  );
  mux_rr_arbiter #(.MAX_HOLD(1), .CNT_W(3)) dut1 (
    .clk(clk), .reset(reset1), .req(req1), .grant(grant1),
    .select1(select1_1), .select2(select2_1), .owner(owner1), .busy(busy1)
  );
  task automatic chk(input string name, input int idx, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d] got grant/s2s1/owner/busy=%b required %b", name, idx, act, exp);
  endtask
  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g, input logic [1:0] o, input logic b);
    vec_t t;
    t.rst = r; t.req = rq; t.g = g; t.o = o; t.b = b;
    v.push_back(t);
  endtask
  initial begin
    logic [3:0] alt [4];
    reset = 1; req = 0; reset1 = 1; req1 = 0;
    add(1, 4'b1111, 4'b0000, 2'd3, 0);
    add(0, 4'b1111, 4'b0001, 2'd0, 1);
    for (int i = 0; i < 3; i++) add(0, 4'b1111, 4'b0001, 2'd0, 1);
    for (int c = 1; c < 4; c++)
      for (int i = 0; i < 4; i++) add(0, 4'b1111, 4'b0001 << c, 2'(c), 1);
    add(0, 4'b1111, 4'b0001, 2'd0, 1);
    add(0, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, 4'b0011, 4'b0010, 2'd1, 1);
    add(0, 4'b1010, 4'b0010, 2'd1, 1);
    add(0, 4'b1000, 4'b1000, 2'd3, 1);
    add(0, 4'b0000, 4'b0000, 2'd3, 0);
    for (int i = 0; i < 4; i++) add(0, 4'b0100, 4'b0100, 2'd2, 1);
    add(0, 4'b0100, 4'b0100, 2'd2, 1);
    add(0, 4'b0100, 4'b0100, 2'd2, 1);
    add(1, 4'b1111, 4'b0000, 2'd3, 0);
    add(0, 4'b0010, 4'b0010, 2'd1, 1);
    foreach (v[i]) begin
      reset = v[i].rst; req = v[i].req;
      @(posedge clk); #1;
      chk("hold4", i, {grant, select2, select1, owner, busy}, {v[i].g, v[i].o, v[i].o, v[i].b});
    end
    @(negedge clk);
    reset1 = 1; req1 = 4'b1010;
    @(posedge clk); #1;
    chk("rst1", 0, {grant1, select2_1, select1_1, owner1, busy1}, {4'b0000, 2'd3, 2'd3, 1'b0});
    reset1 = 0;
    alt[0] = 4'b0010; alt[1] = 4'b1000; alt[2] = 4'b0010; alt[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("hold1", i, {grant1, select2_1, select1_1, owner1, busy1},
          {alt[i], alt[i][3] ? 2'd3 : 2'd1, alt[i][3] ? 2'd3 : 2'd1, 1'b1});
    end
    reset1 = 1;
    @(posedge clk); #1;
    chk("midrst1", 0, {grant1, select2_1, select1_1, owner1, busy1}, {4'b0000, 2'd3, 2'd3, 1'b0});
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
